// File: rtl/axilite_rr_master.sv
// Two-client round-robin AXI-Lite master, one transaction in flight.
// Sequences AW/W/B or AR/R and returns a one-cycle response pulse.
module axilite_rr_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic [1:0]  rsp0_resp,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic [1:0]  rsp1_resp,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, AW, W, B, AR, R, RSP
  } state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic [31:0]   wdata_q;

  logic          pick1;
  logic          any_req;
  logic          sel_write;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          hs;
  logic          phase;
  logic          tmo;
  logic          fin;
  logic [31:0]   fin_rdata;
  logic [1:0]    fin_resp;

  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid):  pick1 = ~last_grant;
      (req1_valid & ~req0_valid): pick1 = 1'b1;
      default:                    pick1 = 1'b0;
    endcase
  end

  assign any_req    = req0_valid | req1_valid;
  assign req0_ready = (state == IDLE) & req0_valid & ~pick1;
  assign req1_ready = (state == IDLE) & pick1;
  assign sel_write  = pick1 ? req1_write : req0_write;
  assign sel_addr   = pick1 ? req1_addr  : req0_addr;
  assign sel_wdata  = pick1 ? req1_wdata : req0_wdata;
  assign busy       = (state != IDLE);

  always_comb begin
    hs = 1'b0;
    unique case (state)
      AW:      hs = m_axi_awready;
      W:       hs = m_axi_wready;
      B:       hs = m_axi_bvalid;
      AR:      hs = m_axi_arready;
      R:       hs = m_axi_rvalid;
      default: hs = 1'b0;
    endcase
  end

  assign phase = (state == AW) | (state == W) | (state == B)
               | (state == AR) | (state == R);

  // a handshake in the final cycle beats the watchdog
  assign tmo = phase & ~hs & (cnt == LAST);

  assign fin = tmo
             | ((state == B) & m_axi_bvalid)
             | ((state == R) & m_axi_rvalid);

  assign fin_rdata = ((state == R) & m_axi_rvalid) ? m_axi_rdata : '0;
  assign fin_resp  = tmo           ? 2'b10
                   : (state == B)  ? m_axi_bresp
                   :                 m_axi_rresp;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cnt           <= '0;
      wdata_q       <= '0;
      grant         <= 1'b0;
      timeout_err   <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp0_rdata    <= '0;
      rsp0_resp     <= '0;
      rsp1_valid    <= 1'b0;
      rsp1_rdata    <= '0;
      rsp1_resp     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      rsp0_valid <= fin & ~grant;
      rsp0_rdata <= (fin & ~grant) ? fin_rdata : '0;
      rsp0_resp  <= (fin & ~grant) ? fin_resp  : '0;
      rsp1_valid <= fin & grant;
      rsp1_rdata <= (fin & grant) ? fin_rdata : '0;
      rsp1_resp  <= (fin & grant) ? fin_resp  : '0;

      cnt <= (phase & ~hs & ~tmo) ? cnt + 1'b1 : '0;

      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick1;
            last_grant <= pick1;
            if (sel_write) begin
              state         <= AW;
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= sel_addr;
              wdata_q       <= sel_wdata;
            end else begin
              state         <= AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= sel_addr;
            end
          end
        end
        AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= wdata_q;
            state         <= W;
          end
        end
        W: begin
          if (m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            m_axi_bready <= 1'b1;
            state        <= B;
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            state        <= RSP;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= R;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            state        <= RSP;
          end
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (tmo) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        timeout_err   <= 1'b1;
        state         <= RSP;
      end
    end
  end

endmodule

// File: tb/tb_axilite_rr_master.sv
// Bench for axilite_rr_master: 128-word slave model, random stalls,
// scoreboard of expected responses from a word-level memory model.
module tb_axilite_rr_master;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req0_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0;
  logic        req1_valid = 0, req1_write = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [1:0]  rsp0_resp, rsp1_resp;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
  logic        m_axi_arready = 0, m_axi_rvalid = 0;
  logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
  logic [31:0] m_axi_rdata = 0;
  logic        grant, busy, timeout_err;

  axilite_rr_master #(.TIMEOUT(TO)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_resp(rsp0_resp),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_resp(rsp1_resp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  // slave: 0 random stalls, 1 zero-wait, 2 no awready, 3 no wready
  int          smode = 0;
  logic [31:0] mem [128];
  bit          loaded = 0;
  bit          b_pend = 0, r_pend = 0;
  logic [31:0] aw_a = 0, r_d = 0;
  logic [1:0]  b_r = 0, r_r = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9bdf ^ (i * 32'h0101_0111);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] = init_word(i);
      loaded = 1;
    end
    if (!rstn) begin
      b_pend = 0;
      r_pend = 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) aw_a = m_axi_awaddr;
      if (m_axi_wvalid && m_axi_wready) begin
        b_pend = 1;
        if (aw_a < 128) begin
          mem[aw_a[6:0]] = m_axi_wdata;
          b_r = 2'b00;
        end else b_r = 2'b11;
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend = 1;
        r_d = (m_axi_araddr < 128) ? mem[m_axi_araddr[6:0]] : 32'h0;
        r_r = (m_axi_araddr < 128) ? 2'b00 : 2'b11;
      end
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;
    end
  end

  always @(negedge clk) begin
    m_axi_awready = ($urandom_range(0, 3) != 0);
    m_axi_wready  = ($urandom_range(0, 3) != 0);
    m_axi_arready = ($urandom_range(0, 3) != 0);
    m_axi_bvalid  = b_pend && ($urandom_range(0, 3) != 0);
    m_axi_rvalid  = r_pend && ($urandom_range(0, 3) != 0);
    if (smode == 1) begin
      m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
      m_axi_bvalid = b_pend; m_axi_rvalid = r_pend;
    end
    if (smode == 2) m_axi_awready = 0;
    if (smode == 3) begin
      m_axi_awready = 1; m_axi_wready = 0;
    end
    m_axi_bresp = m_axi_bvalid ? b_r : 2'($urandom);
    m_axi_rresp = m_axi_rvalid ? r_r : 2'($urandom);
    m_axi_rdata = m_axi_rvalid ? r_d : $urandom;
  end

  // reference model: word memory plus round-robin pointer
  typedef struct {
    bit          who;
    logic [31:0] rd;
    logic [1:0]  rs;
  } exp_t;

  logic [31:0] exp_mem [128];
  bit          model_last = 1;
  int          n_chk = 0, n_pass = 0;

  function automatic void predict(input bit wr, input logic [31:0] a,
                                  input logic [31:0] d,
                                  output logic [31:0] rd,
                                  output logic [1:0] rs);
    rd = '0;
    rs = 2'b11;
    if (a < 128) begin
      rs = 2'b00;
      if (wr) exp_mem[a[6:0]] = d;
      else rd = exp_mem[a[6:0]];
    end
  endfunction

  task automatic drive_req(input bit who, input bit v, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
    if (!who) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    model_last = 1;
  endtask

  // issue one request alone and observe its response window
  task automatic single(input bit who, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output bit acc, output int lat,
                        output logic [31:0] rd, output logic [1:0] rs,
                        output int nself, output int nother);
    acc = 0; lat = 0; rd = '0; rs = '0; nself = 0; nother = 0;
    @(negedge clk);
    drive_req(who, 1, wr, a, d);
    #1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if ((who ? req1_ready : req0_ready) === 1'b1) acc = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    drive_req(who, 0, 0, '0, '0);
    #1;
    if (acc) begin
      model_last = who;
      for (int i = 1; i <= 150; i++) begin
        if ((who ? rsp0_valid : rsp1_valid) === 1'b1) nother++;
        if ((who ? rsp1_valid : rsp0_valid) === 1'b1) begin
          nself++;
          if (lat == 0) begin
            lat = i;
            rd = who ? rsp1_rdata : rsp0_rdata;
            rs = who ? rsp1_resp : rsp0_resp;
          end
        end
        if (lat != 0 && i >= lat + 3) break;
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
         m_axi_arvalid, m_axi_rready} !== 5'b0)
      $display("FAIL reset_axi_ctl got %b want 00000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                m_axi_arvalid, m_axi_rready});
    else n_pass++;
    n_chk++;
    if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== 96'h0)
      $display("FAIL reset_axi_data got %h want 0",
               {m_axi_awaddr, m_axi_wdata, m_axi_araddr});
    else n_pass++;
    n_chk++;
    if ({rsp0_valid, rsp0_rdata, rsp0_resp,
         rsp1_valid, rsp1_rdata, rsp1_resp} !== 70'h0)
      $display("FAIL reset_rsp got %h want 0",
               {rsp0_valid, rsp0_rdata, rsp0_resp,
                rsp1_valid, rsp1_rdata, rsp1_resp});
    else n_pass++;
    n_chk++;
    if ({grant, busy, timeout_err} !== 3'b0)
      $display("FAIL reset_status got %b want 000",
               {grant, busy, timeout_err});
    else n_pass++;
    rstn = 1;
    model_last = 1;
  endtask

  task automatic test_plan();
    bit acc; int lat, ns, no;
    logic [31:0] rd, prd; logic [1:0] rs, prs;
    smode = 0;
    single(0, 1, 32'h10, 32'hDEADBEEF, acc, lat, rd, rs, ns, no);
    predict(1, 32'h10, 32'hDEADBEEF, prd, prs);
    n_chk++;
    if ({acc, rs, rd} !== {1'b1, 2'b00, 32'h0})
      $display("FAIL wr10_rsp got acc=%b resp=%b rdata=%h want 1 00 0",
               acc, rs, rd);
    else n_pass++;
    n_chk++;
    if (ns !== 1 || no !== 0)
      $display("FAIL wr10_pulses got self=%0d other=%0d want 1 0", ns, no);
    else n_pass++;
    single(1, 0, 32'h10, 0, acc, lat, rd, rs, ns, no);
    predict(0, 32'h10, 0, prd, prs);
    n_chk++;
    if ({rd, rs} !== {32'hDEADBEEF, 2'b00})
      $display("FAIL rd10_rsp got rdata=%h resp=%b want deadbeef 00",
               rd, rs);
    else n_pass++;
    n_chk++;
    if (ns !== 1 || no !== 0 || grant !== 1'b1)
      $display("FAIL rd10_grant got self=%0d other=%0d grant=%b want 1 0 1",
               ns, no, grant);
    else n_pass++;
    single(0, 1, 32'h200, 32'h12345678, acc, lat, rd, rs, ns, no);
    predict(1, 32'h200, 32'h12345678, prd, prs);
    n_chk++;
    if ({rs, rd} !== {2'b11, 32'h0})
      $display("FAIL wr200 got resp=%b rdata=%h want 11 0", rs, rd);
    else n_pass++;
    single(1, 0, 32'h200, 0, acc, lat, rd, rs, ns, no);
    predict(0, 32'h200, 0, prd, prs);
    n_chk++;
    if ({rs, rd} !== {2'b11, 32'h0})
      $display("FAIL rd200 got resp=%b rdata=%h want 11 0", rs, rd);
    else n_pass++;
    n_chk++;
    if (timeout_err !== 1'b0)
      $display("FAIL plan_timeout_err got %b want 0", timeout_err);
    else n_pass++;
  endtask

  task automatic test_latency();
    bit acc; int lat, ns, no;
    logic [31:0] rd, prd, d; logic [1:0] rs, prs;
    smode = 1;
    d = $urandom;
    single(0, 1, 32'h3, d, acc, lat, rd, rs, ns, no);
    predict(1, 32'h3, d, prd, prs);
    n_chk++;
    if (lat !== 4 || rs !== prs)
      $display("FAIL lat_write got lat=%0d resp=%b want 4 %b", lat, rs, prs);
    else n_pass++;
    single(1, 0, 32'h3, 0, acc, lat, rd, rs, ns, no);
    predict(0, 32'h3, 0, prd, prs);
    n_chk++;
    if (lat !== 3 || rd !== prd)
      $display("FAIL lat_read got lat=%0d rdata=%h want 3 %h", lat, rd, prd);
    else n_pass++;
    smode = 0;
  endtask

  task automatic test_fairness();
    int n[2]; logic [31:0] ad[2];
    int order[$]; exp_t sb[$]; exp_t t;
    int pulses = 0, both = 0;
    logic [31:0] prd; logic [1:0] prs;
    apply_reset();
    n[0] = 4; n[1] = 4;
    ad[0] = $urandom_range(0, 127); ad[1] = $urandom_range(0, 127);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (n[0] == 0 && n[1] == 0 && sb.size() == 0) break;
      drive_req(0, n[0] > 0, 0, ad[0], 0);
      drive_req(1, n[1] > 0, 0, ad[1], 0);
      #1;
      if (req0_ready && req1_ready) both++;
      if (rsp0_valid || rsp1_valid) begin
        pulses++;
        n_chk++;
        if (sb.size() == 0)
          $display("FAIL fair_rsp got unexpected pulse want none");
        else begin
          t = sb.pop_front();
          if ({rsp1_valid, rsp0_valid,
               t.who ? rsp1_rdata : rsp0_rdata,
               t.who ? rsp1_resp : rsp0_resp} !==
              {t.who, !t.who, t.rd, t.rs})
            $display("FAIL fair_rsp got v=%b%b want who=%0d rdata=%h",
                     rsp1_valid, rsp0_valid, t.who, t.rd);
          else n_pass++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if ((k ? req1_ready : req0_ready) === 1'b1) begin
          order.push_back(k);
          predict(0, ad[k], 0, prd, prs);
          t.who = k[0]; t.rd = prd; t.rs = prs;
          sb.push_back(t);
          n[k]--;
          ad[k] = $urandom_range(0, 127);
        end
      end
      @(negedge clk);
    end
    drive_req(0, 0, 0, 0, 0);
    drive_req(1, 0, 0, 0, 0);
    n_chk++;
    if (order.size() !== 8 || pulses !== 8 || both !== 0)
      $display("FAIL fair_counts got acc=%0d pulses=%0d both=%0d want 8 8 0",
               order.size(), pulses, both);
    else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_chk++;
      if (order[i] !== i % 2)
        $display("FAIL fair_order[%0d] got %0d want %0d", i, order[i], i % 2);
      else n_pass++;
    end
    model_last = 1;
  endtask

  task automatic test_random();
    bit v[2]; bit w[2]; logic [31:0] ad[2], dd[2];
    int accepted = 0, done = 0;
    bit outst = 0, e0, e1, win;
    exp_t sb[$]; exp_t t;
    logic [31:0] prd; logic [1:0] prs;
    smode = 0;
    v[0] = 0; v[1] = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (accepted >= 60 && !outst) break;
      for (int k = 0; k < 2; k++)
        if (!v[k] && accepted < 60 && $urandom_range(0, 2) == 0) begin
          v[k] = 1;
          w[k] = 1'($urandom_range(0, 1));
          ad[k] = ($urandom_range(0, 7) == 0) ?
                  32'h100 + $urandom_range(0, 255) :
                  32'($urandom_range(0, 127));
          dd[k] = $urandom;
        end
      drive_req(0, v[0], w[0], ad[0], dd[0]);
      drive_req(1, v[1], w[1], ad[1], dd[1]);
      #1;
      e0 = 0; e1 = 0; win = 0;
      if (!outst && (v[0] || v[1])) begin
        win = (v[0] && v[1]) ? !model_last : v[1];
        e0 = !win; e1 = win;
      end
      n_chk++;
      if ({req0_ready, req1_ready} !== {e0, e1})
        $display("FAIL rnd_ready cyc=%0d got %b%b want %b%b",
                 cyc, req0_ready, req1_ready, e0, e1);
      else n_pass++;
      if (rsp0_valid || rsp1_valid) begin
        n_chk++;
        if (sb.size() == 0)
          $display("FAIL rnd_rsp got unexpected pulse want none");
        else begin
          t = sb.pop_front();
          if ({rsp1_valid, rsp0_valid, grant,
               t.who ? rsp1_rdata : rsp0_rdata,
               t.who ? rsp1_resp : rsp0_resp,
               t.who ? rsp0_rdata : rsp1_rdata,
               t.who ? rsp0_resp : rsp1_resp} !==
              {t.who, !t.who, t.who, t.rd, t.rs, 32'h0, 2'b00})
            $display("FAIL rnd_rsp got v=%b%b g=%b d0=%h r0=%b d1=%h r1=%b want who=%0d rdata=%h resp=%b",
                     rsp1_valid, rsp0_valid, grant, rsp0_rdata, rsp0_resp,
                     rsp1_rdata, rsp1_resp, t.who, t.rd, t.rs);
          else n_pass++;
        end
        outst = 0;
        done++;
      end
      if ((e0 && req0_ready) || (e1 && req1_ready)) begin
        model_last = win;
        outst = 1;
        predict(w[win], ad[win], dd[win], prd, prs);
        t.who = win; t.rd = prd; t.rs = prs;
        sb.push_back(t);
        accepted++;
        v[win] = 0;
      end
      @(negedge clk);
    end
    drive_req(0, 0, 0, 0, 0);
    drive_req(1, 0, 0, 0, 0);
    n_chk++;
    if (accepted !== 60 || done !== 60 || timeout_err !== 1'b0)
      $display("FAIL rnd_totals got acc=%0d done=%0d terr=%b want 60 60 0",
               accepted, done, timeout_err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit acc = 0; int cnt = 0, lat, ns, no;
    logic [31:0] rd, prd; logic [1:0] rs, prs;
    apply_reset();
    smode = 2;
    drive_req(0, 1, 1, 32'h5, 32'hCAFEF00D);
    #1;
    for (int i = 0; i < 10 && !acc; i++) begin
      if (req0_ready === 1'b1) acc = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (m_axi_awvalid !== 1'b1) break;
      cnt++;
      @(negedge clk); #1;
    end
    n_chk++;
    if (!acc || cnt !== TO)
      $display("FAIL to_awvalid_cycles got acc=%b cycles=%0d want 1 %0d",
               acc, cnt, TO);
    else n_pass++;
    n_chk++;
    if ({rsp0_valid, rsp0_resp, rsp0_rdata, rsp1_valid, m_axi_wvalid}
        !== {1'b1, 2'b10, 32'h0, 1'b0, 1'b0})
      $display("FAIL to_rsp got v=%b resp=%b rdata=%h v1=%b wv=%b want 1 10 0 0 0",
               rsp0_valid, rsp0_resp, rsp0_rdata, rsp1_valid, m_axi_wvalid);
    else n_pass++;
    model_last = 0;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if ({timeout_err, busy} !== 2'b10)
      $display("FAIL to_sticky got terr=%b busy=%b want 1 0", timeout_err, busy);
    else n_pass++;
    smode = 0;
    single(1, 0, 32'h5, 0, acc, lat, rd, rs, ns, no);
    predict(0, 32'h5, 0, prd, prs);
    n_chk++;
    if ({rd, rs, timeout_err} !== {prd, prs, 1'b1})
      $display("FAIL to_after got rdata=%h resp=%b terr=%b want %h %b 1",
               rd, rs, timeout_err, prd, prs);
    else n_pass++;
    apply_reset();
    #1;
    n_chk++;
    if (timeout_err !== 1'b0)
      $display("FAIL to_clear got %b want 0", timeout_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc = 0, inw = 0, got = 0;
    int pulses = 0;
    logic [31:0] prd, rd = 0; logic [1:0] prs;
    smode = 3;
    @(negedge clk);
    drive_req(0, 1, 1, 32'h7, 32'hA5A5A5A5);
    #1;
    for (int i = 0; i < 10 && !acc; i++) begin
      if (req0_ready === 1'b1) acc = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 20 && !inw; i++) begin
      if (m_axi_wvalid === 1'b1) inw = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    n_chk++;
    if (!acc || !inw)
      $display("FAIL mid_reach_w got acc=%b wvalid=%b want 1 1", acc, inw);
    else n_pass++;
    rstn = 0;
    @(negedge clk);
    #1;
    n_chk++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
         m_axi_rready, busy, rsp0_valid, rsp1_valid, grant} !== 9'b0)
      $display("FAIL mid_ctl got %b want 0",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                m_axi_rready, busy, rsp0_valid, rsp1_valid, grant});
    else n_pass++;
    n_chk++;
    if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== 96'h0)
      $display("FAIL mid_data got %h want 0",
               {m_axi_awaddr, m_axi_wdata, m_axi_araddr});
    else n_pass++;
    rstn = 1;
    model_last = 1;
    smode = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    n_chk++;
    if (pulses !== 0)
      $display("FAIL mid_no_pulse got %0d want 0", pulses);
    else n_pass++;
    @(negedge clk);
    drive_req(0, 1, 0, 32'd20, 0);
    drive_req(1, 1, 0, 32'd21, 0);
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL mid_first_grant got %b%b want 10", req0_ready, req1_ready);
    else n_pass++;
    @(negedge clk);
    drive_req(0, 0, 0, 0, 0);
    drive_req(1, 0, 0, 0, 0);
    model_last = 0;
    predict(0, 32'd20, 0, prd, prs);
    for (int i = 0; i < 150 && !got; i++) begin
      #1;
      if (rsp0_valid === 1'b1) begin
        got = 1;
        rd = rsp0_rdata;
      end else @(negedge clk);
    end
    n_chk++;
    if (!got || rd !== prd)
      $display("FAIL mid_after got seen=%b rdata=%h want 1 %h", got, rd, prd);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_plan();
    test_latency();
    test_fairness();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
